// File: rtl/bin_img_pkg.sv
// Shared constants and types for the binary image bounding-box path.
// Default geometry matches the upstream bin_compare stream.
package bin_img_pkg;

  localparam int DEF_H_DISP = 450;
  localparam int DEF_V_DISP = 280;

  typedef enum logic {
    IDLE,
    ACTIVE
  } bbox_state_e;

endpackage

// File: rtl/bin_pix_coord.sv
// Pixel column/row tracker for a vsync/href stream.
// Flags pixels outside the frame geometry and malformed lines.
module bin_pix_coord #(
  parameter int IMG_H_DISP = 450,
  parameter int IMG_V_DISP = 280,
  parameter int CW = $clog2(IMG_H_DISP + 1),
  parameter int RW = $clog2(IMG_V_DISP + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          active,
  input  logic          clear,
  input  logic          vsync,
  input  logic          href,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          pix_ok,
  output logic          geom_err,
  output logic          rows_bad
);

  localparam logic [CW-1:0] H_C = CW'(IMG_H_DISP);
  localparam logic [RW-1:0] V_C = RW'(IMG_V_DISP);

  logic          href_r;
  logic          pix;
  logic          col_ovf;
  logic          row_ovf;
  logic          line_end;
  logic [RW-1:0] rows_done;

  always_comb begin
    pix      = active & vsync & href;
    col_ovf  = (col >= H_C);
    row_ovf  = (row >= V_C);
    pix_ok   = pix & ~col_ovf & ~row_ovf;
    line_end = active & href_r & ~href;
    geom_err = (pix & (col_ovf | row_ovf))
             | (line_end & (col != H_C));
    // Include a line closing on this very cycle.
    rows_done = (line_end && !row_ovf) ? row + 1'b1 : row;
    rows_bad  = (rows_done != V_C);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      href_r <= 1'b0;
      col    <= '0;
      row    <= '0;
    end else begin
      href_r <= href;
      if (clear) begin
        col <= '0;
        row <= '0;
      end else if (line_end) begin
        col <= '0;
        if (!row_ovf) row <= row + 1'b1;
      end else if (pix && !col_ovf) begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/bin_bbox_detect.sv
// Per-frame bounding box and foreground count of a binary stream.
// Results are reported with a one-cycle pulse at end of frame.
module bin_bbox_detect
  import bin_img_pkg::*;
#(
  parameter int IMG_H_DISP = DEF_H_DISP,
  parameter int IMG_V_DISP = DEF_V_DISP,
  parameter int X_W = $clog2(IMG_H_DISP),
  parameter int Y_W = $clog2(IMG_V_DISP),
  parameter int N_W = $clog2(IMG_H_DISP * IMG_V_DISP + 1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           per_img_vsync,
  input  logic           per_img_href,
  input  logic           per_img_bit,
  output logic           bbox_valid,
  output logic           bbox_empty,
  output logic [X_W-1:0] bbox_x_min,
  output logic [X_W-1:0] bbox_x_max,
  output logic [Y_W-1:0] bbox_y_min,
  output logic [Y_W-1:0] bbox_y_max,
  output logic [N_W-1:0] bbox_pix_cnt,
  output logic           frame_err
);

  localparam int CW = $clog2(IMG_H_DISP + 1);
  localparam int RW = $clog2(IMG_V_DISP + 1);
  localparam logic [N_W-1:0] CNT_MAX = '1;

  bbox_state_e    state;
  logic           vsync_r;
  logic           rise;
  logic           fall;
  logic           clear;
  logic [CW-1:0]  col;
  logic [RW-1:0]  row;
  logic           pix_ok;
  logic           geom_err;
  logic           rows_bad;
  logic [X_W-1:0] px;
  logic [Y_W-1:0] py;
  logic [X_W-1:0] x_lo;
  logic [X_W-1:0] x_hi;
  logic [Y_W-1:0] y_lo;
  logic [Y_W-1:0] y_hi;
  logic [N_W-1:0] cnt;
  logic           err;

  assign rise  = per_img_vsync & ~vsync_r;
  assign fall  = ~per_img_vsync & vsync_r;
  assign clear = rise & (state == IDLE);
  assign px    = col[X_W-1:0];
  assign py    = row[Y_W-1:0];

  bin_pix_coord #(
    .IMG_H_DISP (IMG_H_DISP),
    .IMG_V_DISP (IMG_V_DISP),
    .CW         (CW),
    .RW         (RW)
  ) u_coord (
    .clk      (clk),
    .rst      (rst),
    .active   (state == ACTIVE),
    .clear    (clear),
    .vsync    (per_img_vsync),
    .href     (per_img_href),
    .col      (col),
    .row      (row),
    .pix_ok   (pix_ok),
    .geom_err (geom_err),
    .rows_bad (rows_bad)
  );

  // vsync_r follows the input through reset so a frame interrupted by
  // reset is not mistaken for a new frame start.
  always_ff @(posedge clk) begin
    vsync_r <= per_img_vsync;
    if (rst) begin
      state        <= IDLE;
      x_lo         <= '1;
      x_hi         <= '0;
      y_lo         <= '1;
      y_hi         <= '0;
      cnt          <= '0;
      err          <= 1'b0;
      bbox_valid   <= 1'b0;
      bbox_empty   <= 1'b0;
      bbox_x_min   <= '0;
      bbox_x_max   <= '0;
      bbox_y_min   <= '0;
      bbox_y_max   <= '0;
      bbox_pix_cnt <= '0;
      frame_err    <= 1'b0;
    end else begin
      bbox_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rise) begin
            state <= ACTIVE;
            x_lo  <= '1;
            x_hi  <= '0;
            y_lo  <= '1;
            y_hi  <= '0;
            cnt   <= '0;
            err   <= 1'b0;
          end
        end
        ACTIVE: begin
          if (fall) begin
            state        <= IDLE;
            bbox_valid   <= 1'b1;
            bbox_empty   <= (cnt == '0);
            bbox_x_min   <= (cnt == '0) ? '0 : x_lo;
            bbox_x_max   <= (cnt == '0) ? '0 : x_hi;
            bbox_y_min   <= (cnt == '0) ? '0 : y_lo;
            bbox_y_max   <= (cnt == '0) ? '0 : y_hi;
            bbox_pix_cnt <= cnt;
            frame_err    <= err | geom_err | rows_bad;
          end else begin
            if (geom_err) err <= 1'b1;
            if (pix_ok && per_img_bit) begin
              if (px < x_lo) x_lo <= px;
              if (px > x_hi) x_hi <= px;
              if (py < y_lo) y_lo <= py;
              if (py > y_hi) y_hi <= py;
              if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bin_bbox_detect.sv
// Scoreboard bench for bin_bbox_detect on a reduced 30x20 geometry.
// Expected reports are queued as frames are driven.
module tb_bin_bbox_detect;

  localparam int H  = 30;
  localparam int V  = 20;
  localparam int XW = $clog2(H);
  localparam int YW = $clog2(V);
  localparam int NW = $clog2(H * V + 1);

  typedef struct packed {
    logic          empty;
    logic [XW-1:0] x0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y0;
    logic [YW-1:0] y1;
    logic [NW-1:0] cnt;
    logic          err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic vs  = 1'b0;
  logic hr  = 1'b0;
  logic bt  = 1'b0;

  logic          bbox_valid;
  logic          bbox_empty;
  logic [XW-1:0] bbox_x_min;
  logic [XW-1:0] bbox_x_max;
  logic [YW-1:0] bbox_y_min;
  logic [YW-1:0] bbox_y_max;
  logic [NW-1:0] bbox_pix_cnt;
  logic          frame_err;
  exp_t          obs;

  exp_t sbq[$];
  int   total  = 0;
  int   bad    = 0;
  int   pulses = 0;
  logic prev_v = 1'b0;

  always #5 clk = ~clk;

  bin_bbox_detect #(
    .IMG_H_DISP (H),
    .IMG_V_DISP (V)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .per_img_vsync (vs),
    .per_img_href  (hr),
    .per_img_bit   (bt),
    .bbox_valid    (bbox_valid),
    .bbox_empty    (bbox_empty),
    .bbox_x_min    (bbox_x_min),
    .bbox_x_max    (bbox_x_max),
    .bbox_y_min    (bbox_y_min),
    .bbox_y_max    (bbox_y_max),
    .bbox_pix_cnt  (bbox_pix_cnt),
    .frame_err     (frame_err)
  );

  assign obs = {bbox_empty, bbox_x_min, bbox_x_max, bbox_y_min,
                bbox_y_max, bbox_pix_cnt, frame_err};

  function automatic int line_len(int mode, int r);
    if (mode == 4 && r == 3) return H - 10;
    if (mode == 5 && r == 7) return H + 2;
    return H;
  endfunction

  function automatic bit pix(int mode, int r, int c);
    case (mode)
      0:       return 1'b0;
      1, 6:    return (r == 10 && c == 20);
      3:       return (r == 5 && c == 25) || (r == 15 && c == 7);
      default: return 1'b1;
    endcase
  endfunction

  function automatic exp_t calc(int mode, int nl);
    exp_t e;
    int n  = 0;
    int xa = H;
    int xb = 0;
    int ya = V;
    int yb = 0;
    bit er = (nl != V);
    for (int r = 0; r < nl; r++) begin
      if (line_len(mode, r) != H) er = 1'b1;
      for (int c = 0; c < line_len(mode, r); c++) begin
        if (pix(mode, r, c) && c < H && r < V) begin
          n++;
          if (c < xa) xa = c;
          if (c > xb) xb = c;
          if (r < ya) ya = r;
          if (r > yb) yb = r;
        end
      end
    end
    e.empty = (n == 0);
    e.x0    = (n == 0) ? '0 : XW'(xa);
    e.x1    = (n == 0) ? '0 : XW'(xb);
    e.y0    = (n == 0) ? '0 : YW'(ya);
    e.y1    = (n == 0) ? '0 : YW'(yb);
    e.cnt   = NW'(n);
    e.err   = er;
    return e;
  endfunction

  always @(negedge clk) begin
    if (prev_v) begin
      total++;
      if (bbox_valid !== 1'b0) begin
        bad++;
        $display("FAIL valid_width valid=%b want=0", bbox_valid);
      end
    end
    if (bbox_valid === 1'b1) begin
      pulses++;
      total++;
      if (sbq.size() == 0) begin
        bad++;
        $display("FAIL unexpected_report obs=%h want=none", obs);
      end else begin
        automatic exp_t e = sbq.pop_front();
        if (obs !== e) begin
          bad++;
          $display("FAIL report obs=%h want=%h", obs, e);
        end
      end
    end
    prev_v = bbox_valid;
  end

  task automatic drive_frame(int mode, int nl, int gap, bit rep);
    if (rep) sbq.push_back(calc(mode, nl));
    vs = 1'b1;
    hr = 1'b0;
    bt = 1'b0;
    repeat (2) @(negedge clk);
    for (int r = 0; r < nl; r++) begin
      for (int c = 0; c < line_len(mode, r); c++) begin
        hr = 1'b1;
        bt = pix(mode, r, c);
        @(negedge clk);
      end
      hr = 1'b0;
      bt = 1'b0;
      repeat (3) @(negedge clk);
    end
    vs = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      if (g == 0) begin
        total++;
        if (bbox_valid !== rep) begin
          bad++;
          $display("FAIL latency mode=%0d valid=%b want=%b",
                   mode, bbox_valid, rep);
        end
      end
    end
  endtask

  task automatic check_pulses(string name, int got, int want);
    #1;
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s pulses=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({bbox_valid, obs} !== '0) begin
      bad++;
      $display("FAIL reset obs=%h valid=%b want=0", obs, bbox_valid);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_frames();
    int p0 = pulses;
    drive_frame(1, V, 4, 1'b1);
    drive_frame(0, V, 4, 1'b1);
    drive_frame(2, V, 4, 1'b1);
    drive_frame(3, V, 4, 1'b1);
    check_pulses("frames", pulses - p0, 4);
  endtask

  task automatic test_geometry();
    int p0 = pulses;
    drive_frame(4, V, 4, 1'b1);
    drive_frame(5, V, 4, 1'b1);
    drive_frame(6, V - 1, 4, 1'b1);
    drive_frame(7, V + 1, 4, 1'b1);
    check_pulses("geometry", pulses - p0, 4);
  endtask

  task automatic test_reset_mid();
    int p0 = pulses;
    fork
      drive_frame(1, V, 4, 1'b0);
      begin
        repeat (2 + 10 * (H + 3) + 5) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if ({bbox_valid, obs} !== '0) begin
          bad++;
          $display("FAIL mid_reset obs=%h want=0", obs);
        end
        rst = 1'b0;
      end
    join
    check_pulses("mid_reset_fall", pulses - p0, 0);
    drive_frame(1, V, 4, 1'b1);
    check_pulses("after_reset", pulses - p0, 1);
  endtask

  task automatic test_back_to_back();
    int p0 = pulses;
    exp_t e;
    drive_frame(3, V, 10, 1'b1);
    e = calc(3, V);
    total++;
    if (obs !== e) begin
      bad++;
      $display("FAIL hold obs=%h want=%h", obs, e);
    end
    drive_frame(1, V, 1, 1'b1);
    drive_frame(2, V, 10, 1'b1);
    check_pulses("back_to_back", pulses - p0, 3);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_frames();
    test_geometry();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(negedge clk);
    total++;
    if (sbq.size() !== 0) begin
      bad++;
      $display("FAIL missing_reports left=%0d want=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
